led_rgb_axil_master: RTL and testbench
======================================

LED_RGB_AXIL_MASTER -- requirements
Module: led_rgb_axil_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI4-Lite data width; only 32 supported.
REQ-003 SHALL have one clock and a synchronous, active-high reset, as follows:
- aclk  input  1  sole clock; all logic on rising edge.
- areset  input  1  synchronous, active-high reset.

REQ-004 SHALL have the command and response ports:
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when high with cmd_valid.
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  ADDR_WIDTH  target register byte address.
- cmd_wdata  input  32  write data (ignored for reads).
- rsp_valid  output  1  transaction complete.
- rsp_ready  input  1  response consumed.
- rsp_data  output  32  read data; 0 for writes.
- rsp_resp  output  2  captured BRESP/RRESP.

REQ-005 SHALL have the AXI4-Lite master ports: awaddr[ADDR_WIDTH], awprot[3], awvalid (out); awready (in); wdata[32], wstrb[4], wvalid (out); wready (in); bresp[2], bvalid (in); bready (out); araddr[ADDR_WIDTH], arprot[3], arvalid (out); arready (in); rdata[32], rresp[2], rvalid (in); rready (out).

Function
REQ-006 SHALL implement the FSM states IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
REQ-007 SHALL drive cmd_ready=1 only in IDLE; cmd_valid SHALL be ignored in all other states.
REQ-008 On accept, SHALL register addr/data/write and, next cycle, enter WR (write) or RD_ADDR (read).
REQ-009 In WR, SHALL assert awvalid and wvalid together; each SHALL drop the cycle after its own handshake, independently; WR_RESP SHALL be entered when both are done, including a same-cycle double handshake.
REQ-010 In WR_RESP, SHALL drive bready=1; on bvalid, SHALL capture bresp into rsp_resp, set rsp_data=0, and go to RSP.
REQ-011 In RD_ADDR, SHALL assert arvalid until arready, then go to RD_DATA.
REQ-012 In RD_DATA, SHALL drive rready=1; on rvalid, SHALL capture rdata/rresp and go to RSP.
REQ-013 In RSP, SHALL hold rsp_valid=1 with stable rsp_data/rsp_resp until rsp_ready, then return to IDLE.
REQ-014 SHALL never make any *valid depend combinationally on the matching *ready, and SHALL keep address/data stable while valid is high.
REQ-015 SHALL tie awprot=arprot=3'b000 and wstrb=4'b1111.
REQ-016 SHALL, with zero-wait slaves, give latency from cmd accept edge to rsp_valid of 3 cycles for writes and 3 cycles for reads.
REQ-017 SHALL pass cmd_addr unmodified; it SHALL perform no alignment checks.
REQ-018 SHALL not retry on non-OKAY responses; the response is reported only.

Reset
REQ-019 While areset=1, SHALL set state=IDLE and drive cmd_ready, awvalid, wvalid, bready, arvalid, rready and rsp_valid to 0; rsp_data, rsp_resp and captured registers SHALL be 0.
REQ-020 Reset asserted mid-transaction SHALL abandon it; all valids SHALL be low on the edge after reset is sampled, and no response SHALL be issued.
REQ-021 SHALL drive cmd_ready=1 the first cycle after areset deasserts.

Configuration
REQ-022 With macro LED_RGB_AXIL_MASTER_ERRCNT_EN defined, SHALL add output err_count[16]: reset 0, +1 on each B/R handshake whose resp != 2'b00, saturating at 16'hFFFF.
REQ-023 Without LED_RGB_AXIL_MASTER_ERRCNT_EN, the err_count port and counter SHALL be absent; other behaviour SHALL be identical.

Structure
REQ-024 Package led_rgb_axil_pkg SHALL hold the state enum, constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, and the default ADDR_WIDTH.
REQ-025 SHALL be a single module with no sub-modules; the FSM and datapath SHALL be in one file.

Verification
REQ-026 Write addr 3'h4 data 32'h0000_0007, slave zero-wait OKAY -> aw/w handshake with awaddr=4 and wdata=7; rsp_valid 3 cycles after accept; rsp_resp=00, rsp_data=0.
REQ-027 Write with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles; bready asserted only afterward.
REQ-028 Read addr 3'h0, rdata=32'hA5A5_0001, rvalid delayed 5 cycles -> rsp_data=32'hA5A5_0001; rsp_valid held 4 cycles while rsp_ready=0.
REQ-029 bresp=2'b10 on two writes (ERRCNT_EN defined) -> rsp_resp=10 each; err_count=2; preset counter 16'hFFFF stays 16'hFFFF.
REQ-030 areset pulsed while in RD_DATA -> arvalid/rready=0 next edge; no rsp_valid; cmd_ready=1 the cycle after release.
REQ-031 cmd_valid held high during a busy write -> second command accepted only after rsp_ready handshake returns FSM to IDLE.

Source files
------------

// File: rtl/led_rgb_axil_pkg.sv
// rtl/led_rgb_axil_pkg.sv - shared types and constants for the LED RGB AXI4-Lite master
package led_rgb_axil_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

endpackage

// File: rtl/led_rgb_axil_master.sv
// rtl/led_rgb_axil_master.sv - single-command AXI4-Lite master bridging a cmd/rsp port pair
//
// Ports:
//   aclk, areset                  clock, synchronous active-high reset
//   cmd_*                         command request (valid/ready, write, addr, wdata)
//   rsp_*                         response (valid/ready, data, resp)
//   aw*/w*/b*/ar*/r*              AXI4-Lite master channels
//   err_count                     only with LED_RGB_AXIL_MASTER_ERRCNT_EN: saturating count
//                                 of B/R handshakes carrying a non-OKAY response
module led_rgb_axil_master
    import led_rgb_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    areset,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_resp,

    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready
`ifdef LED_RGB_AXIL_MASTER_ERRCNT_EN
    ,
    output logic [15:0]             err_count
`endif
);

    state_t                  state;
    state_t                  state_nxt;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    // Per-channel "still owed" flags so AW and W can complete in either order.
    logic                    aw_pend;
    logic                    w_pend;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic [1:0]              rsp_resp_q;

    logic                    b_hs;
    logic                    r_hs;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Valids come only from registered state and pending flags, never from
    // the matching ready. Reset gates every handshake output low at once.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rsp_valid = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = cmd_write ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR: begin
                awvalid = aw_pend;
                wvalid  = w_pend;
                if ((!aw_pend || awready) && (!w_pend || wready)) begin
                    state_nxt = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_nxt = ST_RSP;
                end
            end
            ST_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_nxt = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (areset) begin
            cmd_ready = 1'b0;
            awvalid   = 1'b0;
            wvalid    = 1'b0;
            bready    = 1'b0;
            arvalid   = 1'b0;
            rready    = 1'b0;
            rsp_valid = 1'b0;
        end
    end

    assign b_hs = bready && bvalid;
    assign r_hs = rready && rvalid;

    always_ff @(posedge aclk) begin
        if (areset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            aw_pend    <= 1'b0;
            w_pend     <= 1'b0;
            rsp_data_q <= '0;
            rsp_resp_q <= RESP_OKAY;
        end else begin
            if (state == ST_IDLE && cmd_valid) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                aw_pend <= cmd_write;
                w_pend  <= cmd_write;
            end
            if (state == ST_WR) begin
                if (awready) begin
                    aw_pend <= 1'b0;
                end
                if (wready) begin
                    w_pend <= 1'b0;
                end
            end
            if (b_hs) begin
                rsp_data_q <= '0;
                rsp_resp_q <= bresp;
            end
            if (r_hs) begin
                rsp_data_q <= rdata;
                rsp_resp_q <= rresp;
            end
        end
    end

`ifdef LED_RGB_AXIL_MASTER_ERRCNT_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            err_count <= '0;
        end else if (((b_hs && bresp != RESP_OKAY) || (r_hs && rresp != RESP_OKAY))
                     && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

    assign awaddr   = addr_q;
    assign araddr   = addr_q;
    assign wdata    = wdata_q;
    assign awprot   = 3'b000;
    assign arprot   = 3'b000;
    assign wstrb    = '1;
    assign rsp_data = rsp_data_q;
    assign rsp_resp = rsp_resp_q;

endmodule

// File: tb/tb_led_rgb_axil_master.sv
// tb/tb_led_rgb_axil_master.sv - randomized self-checking bench for led_rgb_axil_master
module tb_led_rgb_axil_master;

    logic        aclk;
    logic        areset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [2:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [2:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [2:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
`ifdef LED_RGB_AXIL_MASTER_ERRCNT_EN
    logic [15:0] err_count;
`endif

    int errors = 0;
    int checks = 0;
    int exp_err = 0;

    led_rgb_axil_master #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
`ifdef LED_RGB_AXIL_MASTER_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_slave();
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rsp_ready = 0;
    endtask

    task automatic check_err_count();
`ifdef LED_RGB_AXIL_MASTER_ERRCNT_EN
        check_val("err_count", {16'd0, err_count}, exp_err);
`endif
    endtask

    // One command end to end. The slave model waits the given number of
    // cycles before each ready/valid; the response is predicted from the
    // command and the slave's chosen resp/rdata, and the latency from the
    // sum of the waits.
    task automatic do_cmd(input bit wr, input logic [2:0] a, input logic [31:0] d,
                          input int aw_d, input int w_d, input int b_d,
                          input int ar_d, input int r_d, input int rs_d,
                          input logic [1:0] resp, input logic [31:0] rd, input bit hold);
        bit aw_done, w_done, b_done, ar_done, r_done, fin;
        int aw_c, w_c, b_c, ar_c, r_c, rs_c, n, exp_lat;
        @(negedge aclk);
        check_val("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        @(posedge aclk);
        exp_lat = wr ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + ar_d + r_d;
        aw_done = !wr; w_done = !wr; b_done = !wr;
        ar_done = wr;  r_done = wr;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; rs_c = 0; n = 0; fin = 0;
        while (!fin && n < 64) begin
            @(negedge aclk);
            n++;
            if (!hold) cmd_valid = 0;
            clear_slave();
            check_val("busy_cmd_ready", cmd_ready, 0);
            if (n == 1) begin
                check_val("awprot", awprot, 0);
                check_val("arprot", arprot, 0);
                check_val("wstrb", wstrb, 4'hF);
            end
            if (!b_done || !r_done) begin
                check_val("rsp_valid_early", rsp_valid, 0);
                check_val("awvalid", awvalid, wr && !aw_done);
                check_val("wvalid", wvalid, wr && !w_done);
                check_val("bready", bready, wr && aw_done && w_done && !b_done);
                check_val("arvalid", arvalid, !wr && !ar_done);
                check_val("rready", rready, !wr && ar_done && !r_done);
                if (wr && aw_done && w_done) begin
                    bvalid = (b_c == b_d); b_c++; bresp = resp;
                end
                if (wr && !aw_done) begin
                    check_val("awaddr", awaddr, a);
                    awready = (aw_c == aw_d); aw_c++;
                end
                if (wr && !w_done) begin
                    check_val("wdata", wdata, d);
                    wready = (w_c == w_d); w_c++;
                end
                if (!wr && ar_done) begin
                    rvalid = (r_c == r_d); r_c++; rdata = rd; rresp = resp;
                end
                if (!wr && !ar_done) begin
                    check_val("araddr", araddr, a);
                    arready = (ar_c == ar_d); ar_c++;
                end
                b_done  = b_done  | bvalid;
                aw_done = aw_done | awready;
                w_done  = w_done  | wready;
                r_done  = r_done  | rvalid;
                ar_done = ar_done | arready;
            end else begin
                if (rs_c == 0) check_val("latency", n, exp_lat);
                check_val("rsp_valid", rsp_valid, 1);
                check_val("rsp_data", rsp_data, wr ? 32'd0 : rd);
                check_val("rsp_resp", rsp_resp, resp);
                rsp_ready = (rs_c == rs_d); rs_c++;
                fin = rsp_ready;
            end
        end
        if (!fin) check_val("rsp_timeout", 0, 1);
        if (resp != 2'b00) exp_err = (exp_err == 65535) ? 65535 : exp_err + 1;
        @(negedge aclk);
        clear_slave();
        check_val("rsp_valid_drop", rsp_valid, 0);
        check_val("back_idle", cmd_ready, 1);
        cmd_valid = 0;
        check_err_count();
    endtask

    initial begin
        logic [1:0] rr;
        areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        bresp = 0; rdata = 0; rresp = 0;
        clear_slave();
        repeat (2) @(negedge aclk);
        check_val("rst_cmd_ready", cmd_ready, 0);
        check_val("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        check_val("rst_rsp_data", rsp_data, 0);
        check_val("rst_rsp_resp", rsp_resp, 0);
        check_err_count();
        areset = 0;
        @(negedge aclk);
        check_val("post_rst_cmd_ready", cmd_ready, 1);

        // Zero-wait write, delayed AW, delayed R with stalled rsp_ready.
        do_cmd(1, 3'h4, 32'h0000_0007, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
        do_cmd(1, 3'h1, 32'h0000_0055, 3, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
        do_cmd(1, 3'h2, 32'h1234_5678, 0, 2, 1, 0, 0, 1, 2'b00, 32'h0, 0);
        do_cmd(0, 3'h0, 32'h0, 0, 0, 0, 0, 5, 4, 2'b00, 32'hA5A5_0001, 0);
        do_cmd(0, 3'h3, 32'h0, 0, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 0);
        // Slave errors are reported, not retried.
        do_cmd(1, 3'h5, 32'h0000_00FF, 0, 0, 0, 0, 0, 0, 2'b10, 32'h0, 0);
        do_cmd(1, 3'h6, 32'h0000_0001, 1, 1, 2, 0, 0, 0, 2'b10, 32'h0, 0);
        // cmd_valid held through a busy write, then reissued once idle.
        do_cmd(1, 3'h7, 32'hCAFE_0001, 2, 1, 1, 0, 0, 2, 2'b00, 32'h0, 1);
        do_cmd(1, 3'h7, 32'hCAFE_0001, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            rr = 2'($urandom_range(0, 3));
            do_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                   rr, $urandom, 0);
        end

        // Reset while waiting in RD_DATA abandons the read.
        @(negedge aclk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 3'h2;
        @(posedge aclk);
        @(negedge aclk);
        cmd_valid = 0;
        check_val("rstmid_arvalid_pre", arvalid, 1);
        arready = 1;
        @(negedge aclk);
        arready = 0;
        check_val("rstmid_rready_pre", rready, 1);
        areset = 1;
        @(negedge aclk);
        check_val("rstmid_arvalid", arvalid, 0);
        check_val("rstmid_rready", rready, 0);
        check_val("rstmid_rsp_valid", rsp_valid, 0);
        check_val("rstmid_cmd_ready", cmd_ready, 0);
        areset = 0;
        rvalid = 1; rdata = 32'h1111_2222; rresp = 2'b10;
        exp_err = 0;
        @(negedge aclk);
        rvalid = 0;
        check_val("rstmid_release_cmd_ready", cmd_ready, 1);
        check_val("rstmid_no_rsp", rsp_valid, 0);
        check_val("rstmid_rsp_data", rsp_data, 0);
        check_val("rstmid_no_rready", rready, 0);
        check_err_count();
        repeat (2) begin
            @(negedge aclk);
            check_val("rstmid_still_idle", {rsp_valid, cmd_ready}, 2'b01);
        end
        do_cmd(0, 3'h1, 32'h0, 0, 0, 0, 1, 1, 0, 2'b01, 32'h0BAD_F00D, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
